dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Byte-addressed data memory with a valid/ready load-store port for the RV32 core.
//  Replaces the plain word-aligned async-read array with the following:
//   - registered, configurable-latency reads
//   - byte/half/word stores via byte lanes
//   - load sign/zero extension
//   - misalignment/range error reporting
//   - a response channel with backpressure
//  Sits between the MEM stage and the on-chip data RAM; one request outstanding at a time.
// PARAMETERS
//  ADDR_W    10   word-address bits; capacity = 2**ADDR_W 32-bit words
//  READ_LAT  1    edges from accept to read response valid; legal 1..4
// PORTS
//  clk_i           in   1   clock, all logic on rising edge
//  rst_i           in   1   synchronous, active-high reset
//  req_valid_i     in   1   request present
//  req_ready_o     out  1   block can accept a request
//  req_we_i        in   1   1 = store, 0 = load
//  req_addr_i      in   32  byte address
//  req_size_i      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned_i  in   1   load zero-extends when 1, sign-extends when 0
//  req_wdata_i     in   32  store data, LSBs used for byte/half
//  rsp_valid_o     out  1   response present
//  rsp_ready_i     in   1   consumer takes response
//  rsp_rdata_o     out  32  extended load data; 0 for stores and errors
//  rsp_err_o       out  1   misaligned, out-of-range or reserved size
// BEHAVIOUR
//  FSM states: IDLE, WAIT, RESP. Reset -> IDLE. Reset outputs:
//   - req_ready_o=1
//   - rsp_valid_o=0
//   - rsp_rdata_o=0
//   - rsp_err_o=0
//  req_ready_o = (state==IDLE). Accept = req_valid_i & req_ready_o at an edge.
//  Error at accept if any of the following holds:
//   - size==11
//   - half with addr[0]!=0
//   - word with addr[1:0]!=0
//   - addr[31:ADDR_W+2]!=0
//   An error request does not touch memory.
//  Store, no error: at the accept edge, write the selected lanes of word addr[ADDR_W+1:2].
//   - byte -> lane addr[1:0] <= wdata[7:0]
//   - half -> lanes {addr[1],0} and {addr[1],1} <= wdata[15:0]
//   - word -> all 4 lanes
//   - other lanes keep their value
//  Loads: word read registered at the accept edge. Extraction uses the same lane rules.
//   - bit 7 (byte) or bit 15 (half) extends unless unsigned
//   - word loads are returned unmodified
//  Latency:
//   - loads: rsp_valid_o rises READ_LAT edges after accept; WAIT holds for READ_LAT-1 cycles
//   - stores and errors: response after 1 edge, irrespective of READ_LAT
//  RESP: rsp_* held stable until rsp_valid_o & rsp_ready_i at an edge; then return to IDLE.
//   - rsp_valid_o drops and req_ready_o rises in the following cycle
//   - peak throughput: one request per READ_LAT+1 cycles
//  Request inputs are ignored while not in IDLE.
//  Memory contents undefined after power-up and not cleared by rst_i.
//  Read-after-write: a load accepted after a store's accept edge returns the new data.
//  Reset mid-operation: pending response discarded, FSM -> IDLE; a store whose accept
//   edge already occurred stays written.
// TESTING
//  Store word 0xDEADBEEF @0x10, then load word @0x10, READ_LAT=1
//   -> rsp_valid 1 cycle after accept, rdata=0xDEADBEEF, err=0.
//  Store byte 0x80 @0x11; signed byte load @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080;
//   word @0x10 -> 0xDEAD80EF.
//  Half load @0x13 -> err=1, rdata=0, memory unchanged.
//   Also check address 0x4<<ADDR_W -> err=1.
//   Also check size=11 -> err=1.
//  READ_LAT=3, load with rsp_ready_i low for 5 cycles
//   -> valid appears 3 edges after accept; rdata/err stable; req_ready_o=0 until handshake.
//  Assert rst_i during WAIT -> next cycle rsp_valid=0, req_ready=1; a later load returns
//   previously stored data.
//  Back-to-back: hold req_valid_i high with 4 requests queued, rsp_ready_i=1
//   -> exactly one accept per READ_LAT+1 cycles; responses returned in order.

Source files
------------

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Byte-addressed data RAM behind a valid/ready load-store port.
// Revision : 1.0
// ============================================================================
module dmem_lsu #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT      = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              uns_q, uns_d;
  logic [31:0]       rd_word_q, rd_word_d;

  logic              accept;
  logic              req_err;
  logic              do_write;
  logic              do_read;
  logic [3:0]        lane_mask;
  logic [31:0]       wr_data;
  logic [31:0]       mem_rd;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  assign word_idx = req_addr_i[ADDR_W+1:2];
  assign accept   = req_valid_i & (state_q == IDLE) & ~rst_i;
  assign do_write = accept & req_we_i & ~req_err;
  assign do_read  = accept & ~req_we_i & ~req_err;

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr_i[0];
      SZ_WORD: req_err = |req_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
    if (|req_addr_i[31:ADDR_W+2]) begin
      req_err = 1'b1;
    end
  end

  // Store data is replicated across lanes so each lane picks its own byte.
  always_comb begin
    lane_mask = 4'b0000;
    wr_data   = req_wdata_i;
    case (req_size_i)
      SZ_BYTE: begin
        lane_mask = 4'b0001 << req_addr_i[1:0];
        wr_data   = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        lane_mask = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{req_wdata_i[15:0]}};
      end
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (do_write && lane_mask[i]) begin
        mem_q[word_idx] <= wr_data[8*i +: 8];
      end
    end

    assign mem_rd[8*i +: 8] = mem_q[word_idx];
  end

  always_comb begin
    err_d     = err_q;
    we_d      = we_q;
    size_d    = size_q;
    lo_d      = lo_q;
    uns_d     = uns_q;
    rd_word_d = rd_word_q;
    if (accept) begin
      err_d  = req_err;
      we_d   = req_we_i;
      size_d = req_size_i;
      lo_d   = req_addr_i[1:0];
      uns_d  = req_unsigned_i;
    end
    if (do_read) begin
      rd_word_d = mem_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      lo_q      <= 2'd0;
      uns_q     <= 1'b0;
      rd_word_q <= 32'h0;
    end else begin
      err_q     <= err_d;
      we_q      <= we_d;
      size_q    <= size_d;
      lo_q      <= lo_d;
      uns_q     <= uns_d;
      rd_word_q <= rd_word_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stores, errors and single-cycle loads skip WAIT entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (do_read && (READ_LAT > 1)) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = rd_word_q[7:0];
      2'd1:    byte_sel = rd_word_q[15:8];
      2'd2:    byte_sel = rd_word_q[23:16];
      default: byte_sel = rd_word_q[31:24];
    endcase
    half_sel = lo_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      SZ_HALF: load_data = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: load_data = rd_word_q;
    endcase
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    rsp_err_o   = (state_q == RESP) & err_q;
    rsp_rdata_o = ((state_q == RESP) && !err_q && !we_q) ? load_data : 32'h0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Directed scoreboard bench for dmem_lsu at READ_LAT 1 and 3.
// Revision : 1.0
// ============================================================================
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;

  logic        rdy1, rdy3, v1, v3, e1, e3;
  logic [31:0] d1, d3;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          lat;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_ready = sel ? rdy3 : rdy1;
  assign rsp_valid = sel ? v3 : v1;
  assign rsp_err   = sel ? e3 : e1;
  assign rsp_rdata = sel ? d3 : d1;

  dmem_lsu #(.ADDR_W(10), .READ_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy1),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_wdata_i(req_wdata), .rsp_valid_o(v1),
    .rsp_ready_i(rsp_ready & ~sel), .rsp_rdata_o(d1), .rsp_err_o(e1)
  );

  dmem_lsu #(.ADDR_W(10), .READ_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & sel), .req_ready_o(rdy3),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_wdata_i(req_wdata), .rsp_valid_o(v3),
    .rsp_ready_i(rsp_ready & sel), .rsp_rdata_o(d3), .rsp_err_o(e3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input logic keep);
    int n;
    n = 0;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed=%0d cycles expected ready", n);
    end
    accept_cyc = cyc;
    exp_q.push_back({ee, ed});
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_wait, input int hold);
    int n;
    logic [32:0] e;
    n = 0;
    rsp_ready = 1'b0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_wait));
    e = '1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vr"}, 32'({rsp_valid, req_ready}), 32'h2);
      chk({tag, "_hold_data"}, rsp_rdata, e[31:0]);
    end
    rsp_ready = 1'b1;
    chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
    chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, 32'({rsp_valid, req_ready}), 32'h1);
  endtask

  task automatic b2b(input string tag);
    int acc [4];
    int got;
    int n;
    logic [32:0] e;
    issue(1'b1, 32'h20, 2'd2, 1'b0, 32'h89AB_CDEF, 32'h0, 1'b0, 1'b0);
    collect({tag, "_st"}, 0, 0);
    fork
      begin
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h89AB_CDEF, 1'b0, 1'b1); acc[0] = accept_cyc;
        issue(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 32'hFFFF_89AB, 1'b0, 1'b1); acc[1] = accept_cyc;
        issue(1'b0, 32'h20, 2'd1, 1'b1, 32'h0, 32'h0000_CDEF, 1'b0, 1'b1); acc[2] = accept_cyc;
        issue(1'b0, 32'h21, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFCD, 1'b0, 1'b1); acc[3] = accept_cyc;
        req_valid = 1'b0;
      end
      begin
        rsp_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 4 && n < 200) begin
          @(posedge clk); #1;
          n++;
          if (rsp_valid) begin
            e = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk({tag, "_b2b_rdata"}, rsp_rdata, e[31:0]);
            chk({tag, "_b2b_err"}, 32'(rsp_err), 32'(e[32]));
            got++;
          end
        end
        chk({tag, "_b2b_count"}, 32'(got), 32'd4);
        rsp_ready = 1'b0;
      end
    join
    for (int i = 1; i < 4; i++) begin
      chk({tag, "_b2b_spacing"}, 32'(acc[i] - acc[i-1]), 32'(lat + 1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_ready", 32'(req_ready), 32'h1);
      chk("reset_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk("reset_err", 32'(rsp_err), 32'h0);
    end

    // READ_LAT = 1 instance
    sel = 1'b0; lat = 1; #1;
    issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    collect("st_word", 0, 0);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    collect("ld_word", lat - 1, 0);
    issue(1'b1, 32'h11, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b0);
    collect("st_byte", 0, 0);
    issue(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    collect("ld_byte_s", lat - 1, 0);
    issue(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    collect("ld_byte_u", lat - 1, 0);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);
    collect("ld_word_merged", lat - 1, 0);
    issue(1'b0, 32'h13, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("ld_half_misal", 0, 0);
    issue(1'b1, 32'h13, 2'd1, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0);
    collect("st_half_misal", 0, 0);
    issue(1'b1, 32'h4 << 10, 2'd2, 1'b0, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
    collect("st_range", 0, 0);
    issue(1'b1, 32'h1010, 2'd2, 1'b0, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
    collect("st_range_alias", 0, 0);
    issue(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("ld_size3", 0, 0);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);
    collect("ld_word_untouched", lat - 1, 0);
    issue(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0, 1'b0);
    collect("ld_half_hi_s", lat - 1, 0);
    b2b("lat1");

    // READ_LAT = 3 instance
    sel = 1'b1; lat = 3; #1;
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    collect("l3_st_word", 0, 0);
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    collect("l3_ld_hold", lat - 1, 5);
    issue(1'b0, 32'h41, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("l3_err", 0, 0);

    // Reset while the load is still in WAIT
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wait_valid", 32'(rsp_valid), 32'h0);
    chk("rst_wait_ready", 32'(req_ready), 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_wait_quiet", 32'(rsp_valid), 32'h0);
    issue(1'b0, 32'h40, 2'd0, 1'b1, 32'h0, 32'h0000_000D, 1'b0, 1'b0);
    collect("l3_after_rst", lat - 1, 0);
    b2b("lat3");

    sel = 1'b0; #1;
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);
    collect("lat1_after_rst", 0, 0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
